// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for eight lanes sharing one 16-bit word mux, with a
// single registered output stage and a valid/ready handshake downstream.
module mux_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           req_i,
    input  logic [8*WIDTH-1:0]   in_data_i,
    input  logic                 out_ready_i,
    output logic [7:0]           ack_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [2:0]           out_sel_o,
    output logic                 out_valid_o,
    output logic                 busy_o
);

    localparam int LANES = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    stage_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         sel_q, sel_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   lane_word [LANES];
    logic [2:0]         win_idx;
    logic               win_found;
    logic               load;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_word[gi] = in_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotating search starting at ptr; 3-bit addition wraps 7 -> 0 for free.
    always_comb begin
        logic [2:0] idx;
        win_found = 1'b0;
        win_idx   = 3'd0;
        idx       = 3'd0;
        for (int k = 0; k < LANES; k++) begin
            idx = ptr_q + 3'(k);
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign load  = ((state_q == ST_EMPTY) || out_ready_i) && win_found;
    assign ack_o = load ? (LANES'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            state_d = ST_FULL;
            ptr_d   = win_idx + 3'd1;
            data_d  = lane_word[win_idx];
            sel_d   = win_idx;
        end else if ((state_q == ST_FULL) && out_ready_i) begin
            state_d = ST_EMPTY;
        end
        busy_d = (state_d == ST_FULL) || (|req_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid_o = (state_q == ST_FULL);
    assign out_data_o  = data_q;
    assign out_sel_o   = sel_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the round-robin output stage.
module tb_mux_rr_arbiter;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         req;
    logic [8*WIDTH-1:0] in_data;
    logic               out_ready;
    logic [7:0]         ack;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               busy;

    logic [WIDTH-1:0]   lane_data [8];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit                 m_valid;
    logic [WIDTH-1:0]   m_data;
    int                 m_sel;
    int                 m_ptr;
    bit                 m_busy;
    logic [7:0]         last_ack;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = lane_data[i];
    end

    mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .in_data_i  (in_data),
        .out_ready_i(out_ready),
        .ack_o      (ack),
        .out_data_o (out_data),
        .out_sel_o  (out_sel),
        .out_valid_o(out_valid),
        .busy_o     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_busy = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".data"},  32'(out_data),  32'(m_data));
        check({tag, ".sel"},   32'(out_sel),   32'(m_sel));
        check({tag, ".busy"},  32'(busy),      32'(m_busy));
    endtask

    // One clock: check ack mid-cycle, advance model at the edge, check registers after it.
    task automatic cycle(input string tag);
        int  w;
        bit  ld;
        logic [7:0] exp_ack;
        @(negedge clk);
        w  = model_winner(req, m_ptr);
        ld = (!m_valid || out_ready) && (w >= 0);
        exp_ack = ld ? 8'(1 << w) : 8'h00;
        check({tag, ".ack"}, 32'(ack), 32'(exp_ack));
        last_ack = exp_ack;
        @(posedge clk);
        if (ld) begin
            m_valid = 1; m_data = lane_data[w]; m_sel = w; m_ptr = (w + 1) % 8;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        m_busy = m_valid || (req != 8'h00);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        check("rst.ack", 32'(ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int  wait_cnt [8];
    logic [7:0] acked;

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        out_ready = 1'b1;
        last_ack = 8'h00;
        for (int i = 0; i < 8; i++) lane_data[i] = WIDTH'(i + 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("init");
        do_reset();

        // All lanes requesting: full rotation then wrap to lane 0
        req = 8'hFF;
        for (int i = 0; i < 9; i++) cycle("rr_all");
        req = 8'h00;
        cycle("drain");

        // Single requester lane 4
        req = 8'h10;
        cycle("lane4");
        req = 8'h00;
        cycle("lane4_drop");

        // Stall with lane 7 waiting behind lane 0
        do_reset();
        req = 8'h81; out_ready = 1'b0;
        cycle("stall_load");
        req = 8'h80;
        for (int i = 0; i < 3; i++) cycle("stall_hold");
        out_ready = 1'b1;
        cycle("stall_release");
        req = 8'h00;
        cycle("stall_drain");

        // Pointer at 7, wrap to lane 0 then lane 6
        do_reset();
        req = 8'h40;
        cycle("ptr7_setup");
        req = 8'h41;
        cycle("wrap_lane0");
        req = 8'h40;
        cycle("wrap_lane6");
        req = 8'h00;
        cycle("wrap_drain");

        // Asynchronous reset while FULL and stalled
        req = 8'h20; out_ready = 1'b0;
        cycle("pre_arst");
        req = 8'h00;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("arst");
        check("arst.ack", 32'(ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req = 8'h08;
        cycle("post_arst");
        req = 8'h00;
        cycle("post_arst_drain");

        // Withdrawn lane-2 request during a stall never reaches the output
        out_ready = 1'b0;
        req = 8'h01;
        cycle("wd_load");
        req = 8'h04;
        cycle("wd_pulse");
        req = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle("wd_after");
            check("wd_no_lane2", 32'(out_valid && out_sel == 3'd2), 32'h0);
        end

        // Randomized traffic obeying requester rules, with fairness tracking
        do_reset();
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
            acked = last_ack;
            for (int i = 0; i < 8; i++) begin
                if (acked[i])
                    check("fair_wait_le7", 32'(wait_cnt[i] <= 7), 32'h1);
                else if (req[i] && acked != 8'h00)
                    wait_cnt[i]++;
            end
            for (int i = 0; i < 8; i++) begin
                if (acked[i]) begin
                    wait_cnt[i] = 0;
                    if ($urandom_range(0, 1) == 1) lane_data[i] = WIDTH'($urandom);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    lane_data[i] = WIDTH'($urandom);
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
